// File: rtl/block_mem.sv
// Game of Life generation storage: 4 rows x 16 cells, async dual read, one write port.
// BLOCK_MEM_DEBUG_PRESET_EN enables the debug strobe that loads a fixed seed board.
module block_mem (
    input  logic        clk,
    input  logic        rst,
    input  logic        debug,
    input  logic [1:0]  array_in_vga,
    output logic [15:0] alive_out_vga,
    input  logic        write_enb,
    input  logic [1:0]  array_selector,
    input  logic [15:0] alive_in_selector,
    output logic [15:0] alive_out_selector
);

    logic [15:0] r_mem [4];

`ifdef BLOCK_MEM_DEBUG_PRESET_EN
    localparam logic [15:0] SEED_ROW0 = 16'hC813;
    localparam logic [15:0] SEED_ROW1 = 16'h338C;
    localparam logic [15:0] SEED_ROW2 = 16'h33CC;
    localparam logic [15:0] SEED_ROW3 = 16'h6186;
`else
    // Without the preset the strobe is deliberately left unconnected.
    logic w_unused_debug;
    assign w_unused_debug = debug;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 4; i++) begin
                r_mem[i] <= 16'h0000;
            end
        end
`ifdef BLOCK_MEM_DEBUG_PRESET_EN
        else if (debug) begin
            r_mem[0] <= SEED_ROW0;
            r_mem[1] <= SEED_ROW1;
            r_mem[2] <= SEED_ROW2;
            r_mem[3] <= SEED_ROW3;
        end
`endif
        else if (write_enb) begin
            r_mem[array_selector] <= alive_in_selector;
        end
    end

    // No write bypass: a row written this cycle shows its old value until the edge.
    assign alive_out_vga      = r_mem[array_in_vga];
    assign alive_out_selector = r_mem[array_selector];

endmodule

// File: tb/tb_block_mem.sv
// Directed self-checking bench for block_mem; expectations follow the build's
// BLOCK_MEM_DEBUG_PRESET_EN setting.
module tb_block_mem;

    logic        clk = 1'b0;
    logic        rst;
    logic        debug;
    logic [1:0]  array_in_vga;
    logic [15:0] alive_out_vga;
    logic        write_enb;
    logic [1:0]  array_selector;
    logic [15:0] alive_in_selector;
    logic [15:0] alive_out_selector;

    int vectors = 0;
    int miscompares = 0;
    logic [15:0] exp_mem [4];

    block_mem dut (
        .clk                (clk),
        .rst                (rst),
        .debug              (debug),
        .array_in_vga       (array_in_vga),
        .alive_out_vga      (alive_out_vga),
        .write_enb          (write_enb),
        .array_selector     (array_selector),
        .alive_in_selector  (alive_in_selector),
        .alive_out_selector (alive_out_selector)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_seed_or_hold();
`ifdef BLOCK_MEM_DEBUG_PRESET_EN
        exp_mem[0] = 16'hC813;
        exp_mem[1] = 16'h338C;
        exp_mem[2] = 16'h33CC;
        exp_mem[3] = 16'h6186;
`endif
    endtask

    task automatic check_all(input string tag);
        for (int r = 0; r < 4; r++) begin
            array_selector = 2'(r);
            array_in_vga   = 2'(3 - r);
            #1;
            chk($sformatf("%s sel row%0d", tag, r), alive_out_selector, exp_mem[r]);
            chk($sformatf("%s vga row%0d", tag, 3 - r), alive_out_vga, exp_mem[3 - r]);
        end
    endtask

    task automatic wr(input logic [1:0] row, input logic [15:0] data);
        array_selector    = row;
        alive_in_selector = data;
        write_enb         = 1'b1;
        step();
        write_enb         = 1'b0;
        exp_mem[row]      = data;
    endtask

    initial begin
        rst = 1'b1;
        debug = 1'b0;
        write_enb = 1'b0;
        array_in_vga = 2'd0;
        array_selector = 2'd0;
        alive_in_selector = 16'h0000;
        for (int r = 0; r < 4; r++) exp_mem[r] = 16'h0000;

        step();
        rst = 1'b0;
        check_all("reset");

        debug = 1'b1;
        step();
        debug = 1'b0;
        set_seed_or_hold();
        check_all("debug_pulse");

        wr(2'd0, 16'h1111);
        wr(2'd1, 16'h2222);
        wr(2'd2, 16'h3333);
        wr(2'd3, 16'h4444);
        check_all("preload");

        wr(2'd2, 16'hA5A5);
        check_all("write_row2");

        array_in_vga      = 2'd1;
        array_selector    = 2'd1;
        alive_in_selector = 16'h1234;
        write_enb         = 1'b1;
        #1;
        chk("rdw vga before edge", alive_out_vga, 16'h2222);
        chk("rdw sel before edge", alive_out_selector, 16'h2222);
        step();
        write_enb = 1'b0;
        chk("rdw vga after edge", alive_out_vga, 16'h1234);
        chk("rdw sel after edge", alive_out_selector, 16'h1234);
        exp_mem[1] = 16'h1234;

        debug             = 1'b1;
        write_enb         = 1'b1;
        array_selector    = 2'd0;
        alive_in_selector = 16'hFFFF;
        step();
        debug     = 1'b0;
        write_enb = 1'b0;
`ifdef BLOCK_MEM_DEBUG_PRESET_EN
        set_seed_or_hold();
`else
        exp_mem[0] = 16'hFFFF;
`endif
        check_all("debug_vs_write");

        wr(2'd1, 16'h0001);
        debug             = 1'b1;
        write_enb         = 1'b1;
        array_selector    = 2'd3;
        alive_in_selector = 16'h0F0F;
        step();
        step();
        step();
        debug     = 1'b0;
        write_enb = 1'b0;
`ifdef BLOCK_MEM_DEBUG_PRESET_EN
        set_seed_or_hold();
`else
        exp_mem[3] = 16'h0F0F;
`endif
        check_all("debug_held");

        rst               = 1'b1;
        debug             = 1'b1;
        write_enb         = 1'b1;
        array_selector    = 2'd2;
        alive_in_selector = 16'hBEEF;
        step();
        rst       = 1'b0;
        debug     = 1'b0;
        write_enb = 1'b0;
        for (int r = 0; r < 4; r++) exp_mem[r] = 16'h0000;
        check_all("reset_priority");

        alive_in_selector = 16'h5555;
        step();
        step();
        check_all("idle_hold");

        wr(2'd3, 16'h8001);
        check_all("write_row3");

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
